// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - state encodings and opcode class constants for the WF8 sequencer
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_FETCH  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_IMMF   = 3'd3,
        SEQ_EXEC   = 3'd4,
        SEQ_MEM    = 3'd5
    } seq_state_t;

    // Compared against opcode[4:1]; JMPI is a full 5-bit match.
    localparam logic [3:0] OP_LB     = 4'b1001;
    localparam logic [3:0] OP_SB     = 4'b1010;
    localparam logic [3:0] OP_JMPADR = 4'b1011;
    localparam logic [4:0] OP_JMPI   = 5'b11000;

    typedef struct packed {
        logic imm;
        logic lb;
        logic sb;
        logic jmpadr;
        logic jmpi;
        logic br;
        logic rfw;
    } op_class_t;

endpackage

// File: rtl/cpu_seq_classify.sv
// rtl/cpu_seq_classify.sv - combinational opcode to instruction-class decode
module cpu_seq_classify
    import cpu_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls        = '0;
        cls.imm    = (opcode[4] & opcode[3]) | (~opcode[4] & ~opcode[3] & opcode[1]);
        cls.lb     = (opcode[4:1] == OP_LB);
        cls.sb     = (opcode[4:1] == OP_SB);
        cls.jmpadr = (opcode[4:1] == OP_JMPADR);
        cls.jmpi   = (opcode == OP_JMPI);
        cls.br     = (opcode[4:3] == 2'b11) && (opcode != OP_JMPI);
        cls.rfw    = (~opcode[4] | (opcode[4:2] == 3'b100)) & ~cls.lb;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/immediate/execute/memory sequencer for the WF8 core
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [4:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_load,
    output logic       imm_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       rf_write_en,
    output logic       instr_done,
    output logic       busy,
    output logic       mem_timeout
);

    localparam int                CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LIM = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  WAIT_PRE = CNT_W'(MAX_WAIT - 1);
    localparam bit                CHECK_EN = (MAX_WAIT != 0);

    seq_state_t       state, state_next;
    op_class_t        cls;
    logic [CNT_W-1:0] wait_cnt;

    cpu_seq_classify u_classify (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter only moves while a transfer is outstanding; the transfer keeps waiting past the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_req) begin
            if (mem_ack) begin
                wait_cnt <= '0;
            end else begin
                if (wait_cnt != WAIT_LIM) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (CHECK_EN && (wait_cnt == WAIT_PRE)) begin
                    mem_timeout <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        imm_load     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        rf_write_en  = 1'b0;
        instr_done   = 1'b0;
        busy         = (state != SEQ_IDLE);

        case (state)
            SEQ_IDLE: begin
                if (run) begin
                    state_next = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = SEQ_DECODE;
                end
            end
            SEQ_DECODE: begin
                state_next = cls.imm ? SEQ_IMMF : SEQ_EXEC;
            end
            SEQ_IMMF: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    imm_load   = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                if (cls.lb | cls.sb) begin
                    state_next = SEQ_MEM;
                end else begin
                    rf_write_en = cls.rfw;
                    pc_load     = cls.jmpi | cls.jmpadr | (cls.br & branch_taken);
                    instr_done  = 1'b1;
                    state_next  = SEQ_IDLE;
                end
            end
            SEQ_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = cls.sb;
                if (mem_ack) begin
                    rf_write_en = cls.lb;
                    instr_done  = 1'b1;
                    state_next  = SEQ_IDLE;
                end
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

endmodule
